muldiv_hilo_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipeline processor. It replaces single-cycle combinational mult/div with an iterative shift-add multiplier and a restoring divider, both at 1 bit per cycle. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, exposes HI/LO for MFHI/MFLO, and raises a stall to the hazard unit while busy.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 32 +++
 rtl/muldiv_hilo_ctrl_sign_fix.sv | 21 ++
 rtl/muldiv_hilo_ctrl.sv | 129 ++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared op codes, sequencer states and operand helpers for the HI/LO multiply/divide unit.
package muldiv_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } mdu_state_e;

  // Per-operation flags latched at start and consumed in FIN.
  typedef struct packed {
    logic is_div;
    logic neg_a;
    logic neg_b;
    logic dz;
  } mdu_ctl_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_sign_fix.sv
// Applies signed-op corrections to the raw magnitude result of the iterative datapath.
module mdu_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic              neg_a,
  input  logic              neg_b,
  input  logic [2*XLEN-1:0] raw,
  output logic [2*XLEN-1:0] res
);
  always_comb begin
    res = raw;
    if (!is_div) begin
      if (neg_a ^ neg_b) res = -raw;
    end else begin
      // Remainder follows the dividend's sign; quotient follows the sign product.
      res[2*XLEN-1:XLEN] = neg_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
      res[XLEN-1:0]      = (neg_a ^ neg_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    end
  end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative 1-bit/cycle multiply/divide sequencer owning HI/LO; stalls EX while busy.
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src0_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic            flush_i,
  input  logic            mf_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            stall_o
);
  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_q;   // product high half / remainder
  logic [XLEN-1:0]  mpl_q;   // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0]  mcd_q;   // multiplicand / divisor magnitude
  mdu_ctl_t         ctl_q;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic             done_q;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_sh;
  logic [XLEN+1:0]  div_trial;
  logic             div_ok;
  logic             last_iter;
  logic             sgn_op;
  logic [2*XLEN-1:0] fixed;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcd_q} : '0);
    div_sh    = {acc_q, mpl_q[XLEN-1]};
    div_trial = {1'b0, div_sh} - {2'b0, mcd_q};
    div_ok    = ~div_trial[XLEN+1];
    last_iter = (cnt_q == CNT_W'(XLEN-1));
    sgn_op    = (op_i == MDU_OP_MULT) || (op_i == MDU_OP_DIV);
  end

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .is_div (ctl_q.is_div),
    .neg_a  (ctl_q.neg_a),
    .neg_b  (ctl_q.neg_b),
    .raw    ({acc_q, mpl_q}),
    .res    (fixed)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      mcd_q   <= '0;
      ctl_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i && !flush_i) begin
          case (mdu_op_e'(op_i))
            MDU_OP_MTHI: hi_q <= src0_i;
            MDU_OP_MTLO: lo_q <= src0_i;
            MDU_OP_MULT, MDU_OP_MULTU: begin
              acc_q   <= '0;
              mcd_q   <= mag32(src0_i, sgn_op);
              mpl_q   <= mag32(src1_i, sgn_op);
              cnt_q   <= '0;
              ctl_q   <= '{is_div: 1'b0, neg_a: sgn_op & src0_i[XLEN-1],
                           neg_b: sgn_op & src1_i[XLEN-1], dz: 1'b0};
              state_q <= ST_MUL;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              acc_q   <= '0;
              mpl_q   <= mag32(src0_i, sgn_op);
              mcd_q   <= mag32(src1_i, sgn_op);
              cnt_q   <= '0;
              ctl_q   <= '{is_div: 1'b1, neg_a: sgn_op & src0_i[XLEN-1],
                           neg_b: sgn_op & src1_i[XLEN-1], dz: (src1_i == '0)};
              state_q <= ST_DIV;
            end
            default: ;
          endcase
        end
        ST_MUL: if (flush_i) state_q <= ST_IDLE;
        else begin
          acc_q <= mul_sum[XLEN:1];
          mpl_q <= {mul_sum[0], mpl_q[XLEN-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= ST_FIN;
        end
        ST_DIV: if (flush_i) state_q <= ST_IDLE;
        else begin
          acc_q <= div_ok ? div_trial[XLEN-1:0] : div_sh[XLEN-1:0];
          mpl_q <= {mpl_q[XLEN-2:0], div_ok};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= ST_DIV == ST_DIV ? ST_FIN : ST_FIN;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          if (!flush_i) begin
            // Divide by zero: remainder path already yields the dividend; quotient is forced.
            hi_q   <= fixed[2*XLEN-1:XLEN];
            lo_q   <= ctl_q.dz ? '1 : fixed[XLEN-1:0];
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign stall_o = busy_o & (start_i | mf_i);

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: arithmetic reference model checked every cycle plus literal pins.
module tb_muldiv_hilo_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] src0_i = '0, src1_i = '0;
  logic        flush_i = 1'b0, mf_i = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, stall_o;

  int n_vec = 0;
  int n_err = 0;

  muldiv_hilo_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src0_i(src0_i), .src1_i(src1_i), .flush_i(flush_i), .mf_i(mf_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI,LO} straight from integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {32'(a % b), 32'(a / b)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: a countdown of remaining busy cycles and the pending result.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (flush_i) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end else if (start_i && !flush_i) begin
        case (op_i)
          3'd4: m_hi = src0_i;
          3'd5: m_lo = src0_i;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            m_pend = ref_res(op_i, src0_i, src1_i);
            m_rem  = 33;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_i) begin
    chk("busy",  32'(busy_o),  32'(m_rem > 0));
    chk("done",  32'(done_o),  32'(m_done));
    chk("hi",    hi_o,         m_hi);
    chk("lo",    lo_o,         m_lo);
    chk("stall", 32'(stall_o), 32'((m_rem > 0) && (start_i || mf_i)));
  end

  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; src0_i = a; src1_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 60) begin
      n++;
      @(posedge clk_i); #1;
    end
    if (n >= 60) chk("timeout", 32'(n), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    pulse(op, a, b);
    wait_idle(n);
    chk({name, ".cycles"}, 32'(n), 32'd33);
    chk({name, ".done"}, 32'(done_o), 32'd1);
    chk({name, ".hi"}, hi_o, ehi);
    chk({name, ".lo"}, lo_o, elo);
  endtask

  initial begin
    int n, s;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.hi", hi_o, 32'h0);
    chk("rst.lo", lo_o, 32'h0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m1",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",      3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("div_z",     3'd2, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_op("divu_z",    3'd3, 32'h80000005, 32'd0,        32'h80000005, 32'hFFFFFFFF);
    run_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    pulse(3'd4, 32'h12345678, 32'd0);
    chk("mthi.hi", hi_o, 32'h12345678);
    chk("mthi.busy", 32'(busy_o), 32'd0);
    chk("mthi.done", 32'(done_o), 32'd0);

    // Second request and an MFxx held through the whole busy window.
    pulse(3'd0, 32'd7, 32'd6);
    start_i = 1'b1; op_i = 3'd1; src0_i = 32'd3; src1_i = 32'd4; mf_i = 1'b1;
    n = 0; s = 0;
    while (busy_o && n < 60) begin
      if (stall_o) s++;
      n++;
      @(posedge clk_i); #1;
    end
    chk("stall.count", 32'(s), 32'd33);
    chk("stall.lo", lo_o, 32'd42);
    chk("stall.idle", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; mf_i = 1'b0;
    chk("stall.second_busy", 32'(busy_o), 32'd1);
    wait_idle(n);
    chk("second.lo", lo_o, 32'd12);

    pulse(3'd6, 32'hDEADBEEF, 32'd1);
    chk("op6.busy", 32'(busy_o), 32'd0);
    chk("op6.lo", lo_o, 32'd12);

    pulse(3'd4, 32'hAAAAAAAA, 32'd0);
    pulse(3'd5, 32'hAAAAAAAA, 32'd0);
    pulse(3'd3, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush.busy", 32'(busy_o), 32'd0);
    chk("flush.hi", hi_o, 32'hAAAAAAAA);
    chk("flush.lo", lo_o, 32'hAAAAAAAA);
    chk("flush.done", 32'(done_o), 32'd0);
    @(posedge clk_i); #1;

    pulse(3'd3, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst.busy", 32'(busy_o), 32'd0);
    chk("midrst.hi", hi_o, 32'h0);
    chk("midrst.lo", lo_o, 32'h0);

    start_i = 1'b1; op_i = 3'd0; src0_i = 32'd2; src1_i = 32'd3; flush_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("startflush.busy", 32'(busy_o), 32'd0);

    pulse(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    chk("b2b.lo", lo_o, 32'd12);
    chk("b2b.hi", hi_o, 32'd0);
    pulse(3'd3, 32'd12, 32'd5);
    chk("b2b.busy", 32'(busy_o), 32'd1);
    wait_idle(n);
    chk("b2b.hi2", hi_o, 32'd2);
    chk("b2b.lo2", lo_o, 32'd2);

    @(posedge clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
